iobus_fabric: RTL and testbench

Parametrised MicroBlaze MCS IO-bus fabric that fans one MCS IO bus master out to `SLAVES` peripheral ports by address region. It tracks one transaction at a time with a small FSM and returns a defined bus-error response for unmapped regions. It also returns the same error response for slaves that never answer. It sits between the MCS IO bus and the peripheral set inside the IO subsystem, replacing fixed-width hand-written muxing.

---
 rtl/iobus_fabric.sv | 208 ++++++++++++++++++++
 tb/tb_iobus_fabric.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_fabric.sv
// MicroBlaze MCS IO-bus fabric: one master fanned out to SLAVES ports by address region.
// Optional macro IOBUS_TIMEOUT_EN adds a WAIT-state timeout that completes with the error response.
module iobus_fabric #(
    parameter int          SLAVES         = 4,
    parameter int          SEL_LSB        = 20,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
    localparam int         SEL_W          = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                 io_clk,
    input  logic                 io_rst_n,
    input  logic                 io_addr_strobe,
    input  logic                 io_read_strobe,
    input  logic                 io_write_strobe,
    input  logic [31:0]          io_address,
    input  logic [3:0]           io_byte_enable,
    input  logic [31:0]          io_write_data,
    output logic [31:0]          io_read_data,
    output logic                 io_ready,
    output logic [SLAVES-1:0]    s_addr_strobe,
    output logic [SLAVES-1:0]    s_read_strobe,
    output logic [SLAVES-1:0]    s_write_strobe,
    output logic [31:0]          s_address,
    output logic [3:0]           s_byte_enable,
    output logic [31:0]          s_write_data,
    input  logic [32*SLAVES-1:0] s_read_data,
    input  logic [SLAVES-1:0]    s_ready,
    output logic                 err_irq,
    output logic [31:0]          err_addr
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [31:0] SLAVES_W = 32'(SLAVES);

    logic [1:0]        state_r;
    logic [SEL_W-1:0]  idx_r;
    logic              rd_r;
    logic              err_r;
    logic [SLAVES-1:0] s_addr_strobe_r;
    logic [SLAVES-1:0] s_read_strobe_r;
    logic [SLAVES-1:0] s_write_strobe_r;
    logic [31:0]       s_address_r;
    logic [3:0]        s_byte_enable_r;
    logic [31:0]       s_write_data_r;
    logic [31:0]       io_read_data_r;
    logic              io_ready_r;
    logic              err_irq_r;
    logic [31:0]       err_addr_r;

    logic [SEL_W-1:0]  sel_idx_s;
    logic              decode_err_s;
    logic              slave_ready_s;
    logic [31:0]       slave_data_s;
    logic              timeout_hit_s;

    function automatic logic [SLAVES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [SLAVES-1:0] vec;
        vec = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (idx == SEL_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    assign sel_idx_s    = io_address[SEL_LSB +: SEL_W];
    assign decode_err_s = ({{(32-SEL_W){1'b0}}, sel_idx_s} >= SLAVES_W);

    // Select the ready and read data of the slave owning the current transaction.
    always_comb begin
        slave_ready_s = 1'b0;
        slave_data_s  = 32'h0000_0000;
        for (int i = 0; i < SLAVES; i++) begin
            if (idx_r == SEL_W'(i)) begin
                slave_ready_s = s_ready[i];
                slave_data_s  = s_read_data[32*i +: 32];
            end else begin
                slave_ready_s = slave_ready_s;
                slave_data_s  = slave_data_s;
            end
        end
    end

`ifdef IOBUS_TIMEOUT_EN
    logic [15:0] cnt_r;

    // Count WAIT cycles; the last permitted WAIT cycle sees TIMEOUT_CYCLES-1.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            cnt_r <= 16'h0000;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= 16'h0000;
        end
    end

    assign timeout_hit_s = (cnt_r == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Transaction FSM with registered strobes and response outputs.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_r          <= ST_IDLE;
            idx_r            <= '0;
            rd_r             <= 1'b0;
            err_r            <= 1'b0;
            s_addr_strobe_r  <= '0;
            s_read_strobe_r  <= '0;
            s_write_strobe_r <= '0;
            s_address_r      <= 32'h0000_0000;
            s_byte_enable_r  <= 4'h0;
            s_write_data_r   <= 32'h0000_0000;
            io_read_data_r   <= 32'h0000_0000;
            io_ready_r       <= 1'b0;
            err_irq_r        <= 1'b0;
            err_addr_r       <= 32'h0000_0000;
        end else begin
            s_addr_strobe_r  <= '0;
            s_read_strobe_r  <= '0;
            s_write_strobe_r <= '0;
            io_ready_r       <= 1'b0;
            err_irq_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (io_addr_strobe) begin
                        s_address_r     <= io_address;
                        s_byte_enable_r <= io_byte_enable;
                        s_write_data_r  <= io_write_data;
                        idx_r           <= sel_idx_s;
                        rd_r            <= io_read_strobe;
                        if (decode_err_s) begin
                            err_r   <= 1'b1;
                            state_r <= ST_RESP;
                        end else begin
                            err_r            <= 1'b0;
                            s_addr_strobe_r  <= onehot(sel_idx_s);
                            s_read_strobe_r  <= io_read_strobe ? onehot(sel_idx_s) : '0;
                            s_write_strobe_r <= io_read_strobe ? '0 : onehot(sel_idx_s);
                            state_r          <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Ready wins over a coincident timeout.
                    if (slave_ready_s) begin
                        if (rd_r) begin
                            io_read_data_r <= slave_data_s;
                        end else begin
                            io_read_data_r <= io_read_data_r;
                        end
                        io_ready_r <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        io_read_data_r <= ERR_DATA;
                        err_addr_r     <= s_address_r;
                        io_ready_r     <= 1'b1;
                        err_irq_r      <= 1'b1;
                        state_r        <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    // Slave and timeout completions arrive with io_ready already high;
                    // decode errors raise it here, one cycle after entering RESP.
                    if (io_ready_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        io_ready_r <= 1'b1;
                        err_irq_r  <= err_r;
                        if (err_r) begin
                            io_read_data_r <= ERR_DATA;
                            err_addr_r     <= s_address_r;
                        end else begin
                            io_read_data_r <= io_read_data_r;
                        end
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_read_data   = io_read_data_r;
    assign io_ready       = io_ready_r;
    assign err_irq        = err_irq_r;
    assign err_addr       = err_addr_r;
    assign s_addr_strobe  = s_addr_strobe_r;
    assign s_read_strobe  = s_read_strobe_r;
    assign s_write_strobe = s_write_strobe_r;
    assign s_address      = s_address_r;
    assign s_byte_enable  = s_byte_enable_r;
    assign s_write_data   = s_write_data_r;

endmodule

// File: tb/tb_iobus_fabric.sv
// Directed self-checking bench for iobus_fabric with SLAVES=3 and TIMEOUT_CYCLES=8.
// Timeout scenarios run only when IOBUS_TIMEOUT_EN is defined.
module tb_iobus_fabric;

    localparam int NS = 3;

    logic          io_clk = 1'b0;
    logic          io_rst_n = 1'b0;
    logic          io_addr_strobe = 1'b0;
    logic          io_read_strobe = 1'b0;
    logic          io_write_strobe = 1'b0;
    logic [31:0]   io_address = 32'h0;
    logic [3:0]    io_byte_enable = 4'h0;
    logic [31:0]   io_write_data = 32'h0;
    logic [31:0]   io_read_data;
    logic          io_ready;
    logic [NS-1:0] s_addr_strobe;
    logic [NS-1:0] s_read_strobe;
    logic [NS-1:0] s_write_strobe;
    logic [31:0]   s_address;
    logic [3:0]    s_byte_enable;
    logic [31:0]   s_write_data;
    logic [32*NS-1:0] s_read_data = '0;
    logic [NS-1:0] s_ready = '0;
    logic          err_irq;
    logic [31:0]   err_addr;

    int n_cmp = 0;
    int n_err = 0;

    iobus_fabric #(
        .SLAVES(NS), .SEL_LSB(20), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .s_addr_strobe(s_addr_strobe), .s_read_strobe(s_read_strobe),
        .s_write_strobe(s_write_strobe), .s_address(s_address),
        .s_byte_enable(s_byte_enable), .s_write_data(s_write_data),
        .s_read_data(s_read_data), .s_ready(s_ready),
        .err_irq(err_irq), .err_addr(err_addr)
    );

    always #5 io_clk = ~io_clk;

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = ~rd;
        io_address      = addr;
        io_byte_enable  = be;
        io_write_data   = wd;
    endtask

    task automatic idle_bus();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_io_ready", {31'h0, io_ready}, 32'h0);
        chk("rst_err_irq", {31'h0, err_irq}, 32'h0);
        chk("rst_rdata", io_read_data, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_s_addr_strobe", {29'h0, s_addr_strobe}, 32'h0);
        chk("rst_s_address", s_address, 32'h0);
        io_rst_n = 1'b1;
        tick();

        // Read slave 2, ready at T+3, foreign ready at T+2, stray strobe at T+1
        start(1'b1, 32'h0020_0004, 4'hF, 32'h0);
        tick(); // T+1
        start(1'b1, 32'h0010_0008, 4'hF, 32'h0);
        chk("rd_s_read_strobe", {29'h0, s_read_strobe}, 32'h4);
        chk("rd_s_addr_strobe", {29'h0, s_addr_strobe}, 32'h4);
        chk("rd_s_write_strobe", {29'h0, s_write_strobe}, 32'h0);
        chk("rd_s_address", s_address, 32'h0020_0004);
        tick(); // T+2
        idle_bus();
        s_ready = 3'b001;
        s_read_data[0 +: 32] = 32'h0BAD_0BAD;
        chk("rd_stray_no_strobe", {29'h0, s_addr_strobe}, 32'h0);
        chk("rd_stray_addr_kept", s_address, 32'h0020_0004);
        chk("rd_t2_ready", {31'h0, io_ready}, 32'h0);
        tick(); // T+3
        s_ready = 3'b100;
        s_read_data[64 +: 32] = 32'h1234_5678;
        chk("rd_foreign_ready_ignored", {31'h0, io_ready}, 32'h0);
        tick(); // T+4
        s_ready = 3'b000;
        chk("rd_io_ready", {31'h0, io_ready}, 32'h1);
        chk("rd_rdata", io_read_data, 32'h1234_5678);
        chk("rd_err_irq", {31'h0, err_irq}, 32'h0);
        tick(); // T+5
        chk("rd_ready_pulse", {31'h0, io_ready}, 32'h0);
        chk("rd_rdata_hold", io_read_data, 32'h1234_5678);

        // Write slave 0 with combinational ready
        start(1'b0, 32'h0000_0100, 4'b0011, 32'hCAFE_F00D);
        tick(); // T+1
        idle_bus();
        s_ready = 3'b001;
        chk("wr_s_write_strobe", {29'h0, s_write_strobe}, 32'h1);
        chk("wr_s_read_strobe", {29'h0, s_read_strobe}, 32'h0);
        chk("wr_s_byte_enable", {28'h0, s_byte_enable}, 32'h3);
        chk("wr_s_write_data", s_write_data, 32'hCAFE_F00D);
        tick(); // T+2
        s_ready = 3'b000;
        chk("wr_io_ready", {31'h0, io_ready}, 32'h1);
        chk("wr_rdata_not_cleared", io_read_data, 32'h1234_5678);
        chk("wr_err_irq", {31'h0, err_irq}, 32'h0);
        chk("wr_data_stable", s_write_data, 32'hCAFE_F00D);
        tick();

        // Decode error, idx 3
        start(1'b1, 32'h0030_0010, 4'hF, 32'h0);
        tick(); // T+1
        idle_bus();
        chk("dec_no_strobe", {29'h0, s_addr_strobe}, 32'h0);
        chk("dec_t1_ready", {31'h0, io_ready}, 32'h0);
        tick(); // T+2
        chk("dec_io_ready", {31'h0, io_ready}, 32'h1);
        chk("dec_err_irq", {31'h0, err_irq}, 32'h1);
        chk("dec_rdata", io_read_data, 32'hDEAD_BEEF);
        chk("dec_err_addr", err_addr, 32'h0030_0010);
        tick(); // T+3
        chk("dec_ready_pulse", {31'h0, io_ready}, 32'h0);
        chk("dec_irq_pulse", {31'h0, err_irq}, 32'h0);

`ifdef IOBUS_TIMEOUT_EN
        // Slave 1 never ready; late ready at T+12
        start(1'b1, 32'h0010_0020, 4'hF, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            idle_bus();
            chk("to_wait_no_ready", {31'h0, io_ready}, 32'h0);
        end
        tick(); // T+9
        chk("to_io_ready", {31'h0, io_ready}, 32'h1);
        chk("to_err_irq", {31'h0, err_irq}, 32'h1);
        chk("to_rdata", io_read_data, 32'hDEAD_BEEF);
        chk("to_err_addr", err_addr, 32'h0010_0020);
        tick(); tick(); tick(); // T+12
        s_ready = 3'b010;
        tick(); // T+13
        s_ready = 3'b000;
        chk("to_late_ready_ignored", {31'h0, io_ready}, 32'h0);
        tick();
        chk("to_late_ready_ignored2", {31'h0, io_ready}, 32'h0);

        // Ready coincident with the limit
        start(1'b1, 32'h0020_0000, 4'hF, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            idle_bus();
        end
        tick(); // T+8
        s_ready = 3'b100;
        s_read_data[64 +: 32] = 32'hA5A5_0008;
        chk("lim_t8_ready", {31'h0, io_ready}, 32'h0);
        tick(); // T+9
        s_ready = 3'b000;
        chk("lim_io_ready", {31'h0, io_ready}, 32'h1);
        chk("lim_rdata", io_read_data, 32'hA5A5_0008);
        chk("lim_err_irq", {31'h0, err_irq}, 32'h0);
        tick();
`endif

        // Reset during WAIT
        start(1'b1, 32'h0010_0000, 4'hF, 32'h0);
        tick(); // T+1
        idle_bus();
        tick(); // T+2
        io_rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", io_read_data, 32'h0);
        chk("mid_rst_err_addr", err_addr, 32'h0);
        chk("mid_rst_s_address", s_address, 32'h0);
        chk("mid_rst_ready", {31'h0, io_ready}, 32'h0);
        tick();
        s_ready = 3'b010;
        chk("mid_rst_hold_ready", {31'h0, io_ready}, 32'h0);
        tick();
        io_rst_n = 1'b1;
        tick();
        s_ready = 3'b000;
        chk("post_rst_no_ready", {31'h0, io_ready}, 32'h0);
        tick();
        chk("post_rst_no_ready2", {31'h0, io_ready}, 32'h0);

        // Next transaction after reset: write slave 2, combinational ready
        start(1'b0, 32'h0020_0040, 4'b1100, 32'h0055_AA00);
        tick(); // T+1
        idle_bus();
        s_ready = 3'b100;
        chk("post_wr_strobe", {29'h0, s_write_strobe}, 32'h4);
        tick(); // T+2
        s_ready = 3'b000;
        chk("post_wr_ready", {31'h0, io_ready}, 32'h1);
        chk("post_wr_err_irq", {31'h0, err_irq}, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
